// File: rtl/ucsbece154b_fifo_ext.sv
// Synchronous FIFO with arbitrary depth, registered or fall-through read port,
// occupancy count, almost-full/empty thresholds, flush and overflow/underflow pulses.
module ucsbece154b_fifo_ext #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NR_ENTRIES = 4,
   parameter int unsigned FWFT       = 0,
   parameter int unsigned AF_THRESH  = NR_ENTRIES - 1,
   parameter int unsigned AE_THRESH  = 1,
   localparam int unsigned CntW      = $clog2(NR_ENTRIES + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  push_i,
   output logic [DATA_WIDTH-1:0] data_o,
   input  logic                  pop_i,
   output logic                  full_o,
   output logic                  valid_o,
   output logic                  almost_full_o,
   output logic                  almost_empty_o,
   output logic [CntW-1:0]       count_o,
   output logic                  overflow_o,
   output logic                  underflow_o
);

   localparam int unsigned PtrW = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1;
   localparam logic [PtrW-1:0] LastIdx  = PtrW'(NR_ENTRIES - 1);
   localparam logic [CntW-1:0] FullCnt  = CntW'(NR_ENTRIES);
   localparam logic [CntW-1:0] AfCnt    = CntW'(AF_THRESH);
   localparam logic [CntW-1:0] AeCnt    = CntW'(AE_THRESH);

   logic [DATA_WIDTH-1:0] mem_q [NR_ENTRIES];
   logic [PtrW-1:0]       head_q, head_d, tail_q, tail_d;
   logic [CntW-1:0]       count_q, count_d;
   logic                  ovf_q, ovf_d, unf_q, unf_d;
   logic                  pop_acc, push_acc;

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == LastIdx) ? '0 : p + 1'b1;
   endfunction

   assign full_o         = (count_q == FullCnt);
   assign valid_o        = (count_q != '0);
   assign almost_full_o  = (count_q >= AfCnt);
   assign almost_empty_o = (count_q <= AeCnt);
   assign count_o        = count_q;
   assign overflow_o     = ovf_q;
   assign underflow_o    = unf_q;

   assign pop_acc  = pop_i && valid_o;
   assign push_acc = push_i && (!full_o || pop_acc);

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q + CntW'(push_acc) - CntW'(pop_acc);
      ovf_d   = push_i && !push_acc;
      unf_d   = pop_i && !valid_o;
      if (push_acc) tail_d = ptr_inc(tail_q);
      if (pop_acc)  head_d = ptr_inc(head_q);
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         ovf_d   = 1'b0;
         unf_d   = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Storage is deliberately left uncleared on reset.
   always_ff @(posedge clk_i) begin
      if (!rst_i && !flush_i && push_acc) mem_q[tail_q] <= data_i;
   end

   if (FWFT != 0) begin : g_fwft
      assign data_o = valid_o ? mem_q[head_q] : '0;
   end else begin : g_reg
      logic [DATA_WIDTH-1:0] data_q;

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            data_q <= '0;
         end else if (!flush_i && pop_acc) begin
            data_q <= mem_q[head_q];
         end
      end

      assign data_o = data_q;
   end

endmodule
